branch_target_buffer: RTL

Fetch-stage partner of the branch history table. It holds a direct-mapped table of branch targets indexed by PC, and combines a table hit with the BHT direction bit to choose next_pc. It takes resolved branches from EX and updates its table. On a misprediction it issues a registered redirect/flush.

---
 rtl/branch_target_buffer_if.sv | 40 ++++
 rtl/branch_target_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/resolve bundle between the pipeline and the branch target buffer.
// The master modport is the pipeline side; the slave modport is the BTB.
interface branch_target_buffer_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] fetch_pc;
  logic            bht_predict;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic [PC_W-1:0] next_pc;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [PC_W-1:0] ex_pc;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispredicts;

  modport master (
    output fetch_pc, bht_predict,
    output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  pred_hit, pred_taken, pred_target, next_pc,
    input  redirect, redirect_pc, flush, stat_hits, stat_mispredicts
  );

  modport slave (
    input  fetch_pc, bht_predict,
    input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output pred_hit, pred_taken, pred_target, next_pc,
    output redirect, redirect_pc, flush, stat_hits, stat_mispredicts
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with registered mispredict redirect/flush.
// Optional hit/mispredict counters are enabled with the BTB_STATS_EN macro.
module branch_target_buffer #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic idx_t idx_of(input logic [PC_W-1:0] pc);
    return pc[2 +: IDX_W];
  endfunction

  function automatic tag_t tag_of(input logic [PC_W-1:0] pc);
    return pc[PC_W-1 -: TAG_W];
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic               redirect_q, redirect_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  idx_t               f_idx_s;
  logic               hit_s;
  logic               taken_s;
  logic [PC_W-1:0]    target_s;
  logic [PC_W-1:0]    next_pc_s;

  idx_t               e_idx_s;
  logic               resolve_s;
  logic               mispredict_s;
  logic               wr_en_s;
  logic               clr_en_s;
  logic [PC_W-1:0]    correct_pc_s;

  // Fetch-side lookup against the table state from before this edge.
  always_comb begin
    f_idx_s  = idx_of(bus.fetch_pc);
    hit_s    = valid_q[f_idx_s] && (tag_q[f_idx_s] == tag_of(bus.fetch_pc));
    taken_s  = hit_s && bus.bht_predict;
    target_s = '0;
    if (hit_s) begin
      target_s = tgt_q[f_idx_s];
    end else begin
      target_s = '0;
    end
    next_pc_s = bus.fetch_pc + PC_STEP;
    if (redirect_q) begin
      next_pc_s = redirect_pc_q;
    end else if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = bus.fetch_pc + PC_STEP;
    end
  end

  // Resolve classification; a resolve arriving under a redirect is wrong-path.
  always_comb begin
    e_idx_s      = idx_of(bus.ex_pc);
    resolve_s    = bus.ex_valid && !redirect_q;
    mispredict_s = 1'b0;
    wr_en_s      = 1'b0;
    clr_en_s     = 1'b0;
    if (resolve_s) begin
      if (bus.ex_is_branch) begin
        if (bus.ex_taken) begin
          wr_en_s      = 1'b1;
          mispredict_s = !bus.ex_pred_taken || (bus.ex_pred_target != bus.ex_target);
        end else begin
          mispredict_s = bus.ex_pred_taken;
        end
      end else if (bus.ex_pred_taken) begin
        mispredict_s = 1'b1;
        clr_en_s     = 1'b1;
      end else begin
        mispredict_s = 1'b0;
      end
    end else begin
      mispredict_s = 1'b0;
    end

    if (bus.ex_is_branch && bus.ex_taken) begin
      correct_pc_s = bus.ex_target;
    end else begin
      correct_pc_s = bus.ex_pc + PC_STEP;
    end

    valid_d = valid_q;
    if (wr_en_s) begin
      valid_d[e_idx_s] = 1'b1;
    end else if (clr_en_s) begin
      valid_d[e_idx_s] = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    redirect_d    = mispredict_s;
    redirect_pc_d = correct_pc_s;
  end

  // Valid bits and the redirect register are cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Tag/target arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_q[e_idx_s] <= tag_of(bus.ex_pc);
      tgt_q[e_idx_s] <= bus.ex_target;
    end
  end

  assign bus.pred_hit    = hit_s;
  assign bus.pred_taken  = taken_s;
  assign bus.pred_target = target_s;
  assign bus.next_pc     = next_pc_s;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush       = redirect_q;

`ifdef BTB_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misp_q, misp_d;

  // Saturating event counters.
  always_comb begin
    hits_d = hits_q;
    misp_d = misp_q;
    if (hit_s && (hits_q != 32'hFFFF_FFFF)) begin
      hits_d = hits_q + 32'd1;
    end else begin
      hits_d = hits_q;
    end
    if (redirect_q && (misp_q != 32'hFFFF_FFFF)) begin
      misp_d = misp_q + 32'd1;
    end else begin
      misp_d = misp_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q <= 32'd0;
      misp_q <= 32'd0;
    end else begin
      hits_q <= hits_d;
      misp_q <= misp_d;
    end
  end

  assign bus.stat_hits        = hits_q;
  assign bus.stat_mispredicts = misp_q;
`else
  assign bus.stat_hits        = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

endmodule
